// File: rtl/mme_pkg.sv
// Shared constants, FSM state and data types for the MME systolic MAC array.
// Default sizing here; modules take the actual widths as parameters.
package mme_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_SIZE  = 4;
  localparam int K_W       = 8;
  localparam int CNT_W     = K_W + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  typedef logic signed [DEF_DW-1:0]    operand_t;
  typedef logic signed [DEF_ACC_W-1:0] accum_t;

endpackage

// File: rtl/mme_pe.sv
// One output-stationary PE: forwards a right, b down and valid right with one
// register each hop; accumulates a*b (mod 2^ACC_W) when valid. No backpressure.
module mme_pe #(
  parameter int DW    = 32,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic signed [DW-1:0]    a_i,
  input  logic signed [DW-1:0]    b_i,
  input  logic                    vld_i,
  output logic signed [DW-1:0]    a_o,
  output logic signed [DW-1:0]    b_o,
  output logic                    vld_o,
  output logic signed [ACC_W-1:0] acc_o
);

  localparam int PW = 2 * DW;

  logic signed [DW-1:0]    a_q, a_d;
  logic signed [DW-1:0]    b_q, b_d;
  logic                    vld_q, vld_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [PW-1:0]    prod;

  always_comb begin
    prod  = PW'(a_i) * PW'(b_i);
    a_d   = a_i;
    b_d   = b_i;
    vld_d = vld_i;
    acc_d = acc_q;
    if (clr_i) begin
      a_d   = '0;
      b_d   = '0;
      vld_d = 1'b0;
      acc_d = '0;
    end else if (vld_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= 1'b0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      vld_q <= vld_d;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign vld_o = vld_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/mme_systolic_array.sv
// SIZE x SIZE output-stationary systolic array computing C = A x B over K beats.
// Busy for K+2*SIZE-2 cycles after start; operands are free-running (no backpressure).
module mme_systolic_array
  import mme_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int ACC_W = DEF_ACC_W,
  parameter int SIZE  = DEF_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [K_W-1:0]          mat_width_i,
  input  logic                    start_i,
  output logic                    done_o,
  input  logic signed [DW-1:0]    a_i     [SIZE],
  input  logic signed [DW-1:0]    b_i     [SIZE],
  output logic signed [ACC_W-1:0] accum_o [SIZE][SIZE]
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [SIZE-2:0]    vsr_q, vsr_d;
  logic [CNT_W-1:0]   last_cnt;
  logic               last;
  logic               fv;
  logic               start_acc;
  logic [SIZE-1:0]    row_vld;

  logic signed [DW-1:0] a_fw [SIZE][SIZE];
  logic signed [DW-1:0] b_fw [SIZE][SIZE];
  logic                 v_fw [SIZE][SIZE];

  assign last_cnt = {1'b0, k_q} + CNT_W'(2 * SIZE - 2);
  assign last     = (cnt_q == last_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      vsr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      vsr_q   <= vsr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_BUSY;
      S_BUSY:  if (last)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done_o    = (state_q == S_IDLE);
    start_acc = (state_q == S_IDLE) && start_i;
    fv        = (state_q == S_BUSY) && (cnt_q != '0) && (cnt_q <= {1'b0, k_q});
  end

  always_comb begin
    cnt_d = cnt_q;
    k_d   = k_q;
    vsr_d = '0;
    if (start_acc) begin
      cnt_d = CNT_W'(1);
      k_d   = mat_width_i;
    end else if (state_q == S_BUSY) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
    // Row i sees the feed window i cycles late, matching the operand pre-skew.
    if (!start_acc) begin
      vsr_d[0] = fv;
      for (int s = 1; s < SIZE - 1; s++) vsr_d[s] = vsr_q[s-1];
    end
  end

  always_comb begin
    row_vld    = '0;
    row_vld[0] = fv;
    for (int r = 1; r < SIZE; r++) row_vld[r] = vsr_q[r-1];
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_row
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      logic signed [DW-1:0] a_in, b_in;
      logic                 v_in;

      if (j == 0) begin : g_left
        assign a_in = a_i[i];
        assign v_in = row_vld[i];
      end else begin : g_inner_h
        assign a_in = a_fw[i][j-1];
        assign v_in = v_fw[i][j-1];
      end

      if (i == 0) begin : g_top
        assign b_in = b_i[j];
      end else begin : g_inner_v
        assign b_in = b_fw[i-1][j];
      end

      mme_pe #(
        .DW    (DW),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start_acc),
        .a_i   (a_in),
        .b_i   (b_in),
        .vld_i (v_in),
        .a_o   (a_fw[i][j]),
        .b_o   (b_fw[i][j]),
        .vld_o (v_fw[i][j]),
        .acc_o (accum_o[i][j])
      );
    end
  end

endmodule

// File: doc/mme_systolic_array.md
Name: mme_systolic_array

Overview:
- SIZE x SIZE output-stationary systolic MAC array; direct consumer of the skewed A-row and B-column operand streams from the two data-provider stages in the MME.
- Computes C = A x B over a shared inner dimension K = mat_width_i.
- Holds the SIZE x SIZE result in place for the drain/write-back stage, and signals completion with done_o.

Parameters:
- DW, 32: operand width (signed two's complement).
- ACC_W, 32: accumulator width; products and sums wrap modulo 2^ACC_W.
- SIZE, 4: array dimension (rows = columns).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mat_width_i  in  8  inner dimension K; sampled on accepted start.
- start_i  in  1  start pulse; accepted only in IDLE.
- done_o  out  1  1 in IDLE (accum_o valid/stable), 0 in BUSY.
- a_i[SIZE]  in  signed DW each  row-operand stream; a_i[i] is pre-skewed by i cycles.
- b_i[SIZE]  in  signed DW each  column-operand stream; b_i[j] is pre-skewed by j cycles.
- accum_o[SIZE][SIZE]  out  signed ACC_W each  accumulator of PE(i,j) = C[i][j].

Behaviour:
- Reset (async, any time, including mid-operation):
  - State goes to IDLE; cnt, latched K, valid shift register, all PE a/b/valid pipeline registers and accumulators clear to 0.
  - done_o=1; accum_o all 0.
- FSM states IDLE and BUSY. cnt is an 8+1-bit counter.
- IDLE:
  - start_i=1 -> BUSY, cnt<=1, K<=mat_width_i, all accumulators <=0 on the same edge.
  - Otherwise hold; accumulators keep their last values.
- BUSY:
  - If cnt == K+2*SIZE-2 -> IDLE, cnt<=0.
  - Else cnt<=cnt+1.
  - start_i is ignored.
- Cycle convention: start sampled at the end of cycle 0; BUSY spans cycles 1..K+2*SIZE-2. done_o is low for exactly K+2*SIZE-2 cycles and returns to 1 in cycle K+2*SIZE-1.
- Feed valid:
  - fv = BUSY && 1<=cnt<=K.
  - Row i valid = fv delayed i cycles, via a SIZE-1 stage shift register that is cleared on start.
  - Inputs outside the valid window are don't-care and must never be accumulated.
- PE(i,j) operands:
  - a/valid taken from a_i[i] and row-i valid when j==0, else from PE(i,j-1) registers.
  - b taken from b_i[j] when i==0, else from PE(i-1,j) register.
- PE(i,j) each cycle:
  - Registers a, b and valid for forwarding right/down (1-cycle latency per hop).
  - If its incoming valid=1: acc <= acc + trunc_ACC_W(a*b).
- Alignment: element k reaches PE(i,j) in cycle 1+i+j+k. The last MAC occurs at the edge ending cycle K+2*SIZE-2.
- K=0: no valid beats; BUSY for 2*SIZE-2 cycles; result all 0.
- accum_o is a direct register output and is stable while IDLE.

Decomposition:
- Package mme_pkg holds:
  - constants DW, ACC_W, SIZE defaults;
  - state enum {S_IDLE, S_BUSY};
  - typedefs for the operand and accumulator types.
- One sub-module, mme_pe: a/b/valid forwarding registers plus the MAC accumulator, with a clr input driven by the accepted start.
- The top instantiates SIZE*SIZE PEs and contains the FSM, cnt and valid skew register.

Test Plan:
- Reset: assert rst for 3 cycles, then release -> done_o=1 and all 16 accum_o=0; assert rst asynchronously between edges -> outputs clear before the next edge.
- Identity: SIZE=4, K=4, A=I, B=[1..16] row-major, correctly skewed -> done_o low exactly 10 cycles, then accum_o = B.
- Signed: K=8, all a=-3, all b=7 -> every accum_o = -168. Drive 0xDEADBEEF on inputs outside the valid window -> result unchanged.
- Back-to-back: after the previous run, start with K=2, all a=b=1 -> every accum_o = 2 (no residue). start_i pulsed mid-BUSY -> ignored; done timing unchanged.
- Wrap/edge: K=1, a=b=0x00010000 -> accum_o = 0 (2^32 wraps). K=0 -> done_o low 6 cycles, accum_o all 0.
- Reset mid-operation: assert rst at cnt=5 of a K=8 run -> immediate done_o=1, accum_o=0; a new start afterwards produces correct results.
